// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: redirect kinds and default vectors.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_BRANCH = 3'd1,
        KIND_JUMP   = 3'd2,
        KIND_JR     = 3'd3,
        KIND_EXC    = 3'd4
    } redirect_kind_e;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational target generation and priority select for the next fetch address.
// A misaligned JR is folded into the exception path here.
module pc_target_sel
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_PC = DEFAULT_EXC_PC
) (
    input  logic [31:0]    pc_add4,
    input  logic           jump_en,
    input  logic [25:0]    jump_index,
    input  logic           branch_en,
    input  logic [15:0]    branch_offset,
    input  logic           jr_en,
    input  logic [31:0]    jr_target,
    input  logic           exc_en,
    output redirect_kind_e req_kind,
    output logic [31:0]    req_target,
    output logic           misalign
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    always_comb begin
        jump_target   = {pc_add4[31:28], jump_index, 2'b00};
        branch_target = pc_add4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        misalign      = jr_en && (jr_target[1:0] != 2'b00) && !exc_en;

        req_kind   = KIND_NONE;
        req_target = pc_add4;
        if (exc_en || misalign) begin
            req_kind   = KIND_EXC;
            req_target = EXC_PC;
        end else if (jr_en) begin
            req_kind   = KIND_JR;
            req_target = jr_target;
        end else if (jump_en) begin
            req_kind   = KIND_JUMP;
            req_target = jump_target;
        end else if (branch_en) begin
            req_kind   = KIND_BRANCH;
            req_target = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with a one-entry pending redirect held across fetch stalls.
// A pending exception is sticky; otherwise the latest request wins.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEFAULT_EXC_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        branch_en,
    input  logic [15:0] branch_offset,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        exc_en,
    output logic [31:0] pc,
    output logic [31:0] pc_add4,
    output logic        redirect_pending,
    output logic        misalign_exc
);

    logic [31:0]    pc_q, pc_d;
    redirect_kind_e pend_kind_q, pend_kind_d;
    logic [31:0]    pend_target_q, pend_target_d;
    logic           misalign_q, misalign_d;

    redirect_kind_e req_kind;
    logic [31:0]    req_target;
    logic           misalign;

    assign pc_add4 = pc_q + 32'(WORD_BYTES);

    pc_target_sel #(
        .EXC_PC(EXC_PC)
    ) u_target_sel (
        .pc_add4      (pc_add4),
        .jump_en      (jump_en),
        .jump_index   (jump_index),
        .branch_en    (branch_en),
        .branch_offset(branch_offset),
        .jr_en        (jr_en),
        .jr_target    (jr_target),
        .exc_en       (exc_en),
        .req_kind     (req_kind),
        .req_target   (req_target),
        .misalign     (misalign)
    );

    always_comb begin
        pc_d          = pc_q;
        pend_kind_d   = pend_kind_q;
        pend_target_d = pend_target_q;
        misalign_d    = misalign;

        if (stall) begin
            // Non-exception requests may not displace a buffered exception.
            if (req_kind != KIND_NONE &&
                !(pend_kind_q == KIND_EXC && req_kind != KIND_EXC)) begin
                pend_kind_d   = req_kind;
                pend_target_d = req_target;
            end
        end else begin
            pend_kind_d = KIND_NONE;
            if (pend_kind_q == KIND_EXC) begin
                pc_d = pend_target_q;
            end else if (req_kind != KIND_NONE) begin
                pc_d = req_target;
            end else if (pend_kind_q != KIND_NONE) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = req_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_kind_q   <= KIND_NONE;
            pend_target_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = (pend_kind_q != KIND_NONE);
    assign misalign_exc     = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer; expected results queue up as stimulus is driven
// and are checked after the following clock edge.
module tb_pc_sequencer;

    typedef struct {
        logic        stall;
        logic        jump_en;
        logic [25:0] jump_index;
        logic        branch_en;
        logic [15:0] branch_offset;
        logic        jr_en;
        logic [31:0] jr_target;
        logic        exc_en;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    localparam int NUM_VECS = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_en;
    logic [25:0] jump_index;
    logic        branch_en;
    logic [15:0] branch_offset;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        exc_en;
    logic [31:0] pc;
    logic [31:0] pc_add4;
    logic        redirect_pending;
    logic        misalign_exc;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[NUM_VECS];

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .jump_en         (jump_en),
        .jump_index      (jump_index),
        .branch_en       (branch_en),
        .branch_offset   (branch_offset),
        .jr_en           (jr_en),
        .jr_target       (jr_target),
        .exc_en          (exc_en),
        .pc              (pc),
        .pc_add4         (pc_add4),
        .redirect_pending(redirect_pending),
        .misalign_exc    (misalign_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic st, input logic je, input logic [25:0] ji,
                                input logic be, input logic [15:0] bo, input logic jre,
                                input logic [31:0] jrt, input logic ex,
                                input logic [31:0] epc, input logic epend, input logic emis);
        vec_t v;
        v.stall = st; v.jump_en = je; v.jump_index = ji;
        v.branch_en = be; v.branch_offset = bo;
        v.jr_en = jre; v.jr_target = jrt; v.exc_en = ex;
        v.exp_pc = epc; v.exp_pend = epend; v.exp_mis = emis;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pushExpect(input logic [31:0] epc, input logic epend, input logic emis);
        exp_t e;
        e.pc = epc; e.pend = epend; e.mis = emis;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        stall         = v.stall;
        jump_en       = v.jump_en;
        jump_index    = v.jump_index;
        branch_en     = v.branch_en;
        branch_offset = v.branch_offset;
        jr_en         = v.jr_en;
        jr_target     = v.jr_target;
        exc_en        = v.exc_en;
        pushExpect(v.exp_pc, v.exp_pend, v.exp_mis);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s scoreboard: actual=empty required=entry", tag);
            return;
        end
        e = sb_q.pop_front();
        checkVal({tag, " pc"}, pc, e.pc);
        checkVal({tag, " pc_add4"}, pc_add4, e.pc + 32'd4);
        checkVal({tag, " pending"}, {31'd0, redirect_pending}, {31'd0, e.pend});
        checkVal({tag, " misalign"}, {31'd0, misalign_exc}, {31'd0, e.mis});
    endtask

    task automatic clearInputs();
        stall = 0; jump_en = 0; jump_index = '0; branch_en = 0; branch_offset = '0;
        jr_en = 0; jr_target = '0; exc_en = 0;
    endtask

    initial begin
        //                st je ji        be bo        jre jrt            ex  exp_pc        pend mis
        vecs[0]  = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_3004, 0, 0);
        vecs[1]  = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_3008, 0, 0);
        vecs[2]  = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_300C, 0, 0);
        vecs[3]  = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'h1000_0040,  0, 32'h1000_0040, 0, 0);
        vecs[4]  = mk(0, 1, 26'h123, 0, 16'h0,    0, 32'h0,          0, 32'h1000_048C, 0, 0);
        vecs[5]  = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC, 0, 0);
        vecs[6]  = mk(0, 1, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_0000, 0, 0);
        vecs[7]  = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'h0000_3010,  0, 32'h0000_3010, 0, 0);
        vecs[8]  = mk(0, 0, 26'h0,   1, 16'hFFFE, 0, 32'h0,          0, 32'h0000_300C, 0, 0);
        vecs[9]  = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'h0000_3010,  0, 32'h0000_3010, 0, 0);
        vecs[10] = mk(0, 1, 26'h40,  1, 16'hFFFE, 0, 32'h0,          0, 32'h0000_0100, 0, 0);
        vecs[11] = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'h0000_3000,  0, 32'h0000_3000, 0, 0);
        vecs[12] = mk(1, 1, 26'h40,  0, 16'h0,    0, 32'h0,          0, 32'h0000_3000, 1, 0);
        vecs[13] = mk(1, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_3000, 1, 0);
        vecs[14] = mk(1, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_3000, 1, 0);
        vecs[15] = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_0100, 0, 0);
        vecs[16] = mk(1, 0, 26'h0,   0, 16'h0,    0, 32'h0,          1, 32'h0000_0100, 1, 0);
        vecs[17] = mk(1, 0, 26'h0,   1, 16'h0010, 0, 32'h0,          0, 32'h0000_0100, 1, 0);
        vecs[18] = mk(1, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_0100, 1, 0);
        vecs[19] = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_4180, 0, 0);
        vecs[20] = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'h0000_3002,  0, 32'h0000_4180, 0, 1);
        vecs[21] = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_4184, 0, 0);
        vecs[22] = mk(0, 0, 26'h0,   0, 16'h0,    1, 32'h0000_3400,  0, 32'h0000_3400, 0, 0);
        vecs[23] = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_3404, 0, 0);
        vecs[24] = mk(0, 1, 26'h10,  1, 16'h0004, 1, 32'h0000_5000,  1, 32'h0000_4180, 0, 0);
        vecs[25] = mk(0, 1, 26'h10,  1, 16'h0004, 1, 32'h0000_5000,  0, 32'h0000_5000, 0, 0);
        vecs[26] = mk(1, 1, 26'h80,  0, 16'h0,    0, 32'h0,          0, 32'h0000_5000, 1, 0);
        vecs[27] = mk(1, 0, 26'h0,   1, 16'h0004, 0, 32'h0,          0, 32'h0000_5000, 1, 0);
        vecs[28] = mk(0, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_5014, 0, 0);
        vecs[29] = mk(1, 1, 26'h80,  0, 16'h0,    0, 32'h0,          0, 32'h0000_5014, 1, 0);
        vecs[30] = mk(0, 0, 26'h0,   1, 16'h0001, 0, 32'h0,          0, 32'h0000_501C, 0, 0);
        vecs[31] = mk(1, 0, 26'h0,   0, 16'h0,    1, 32'h0000_6001,  0, 32'h0000_501C, 1, 1);
        vecs[32] = mk(1, 0, 26'h0,   0, 16'h0,    0, 32'h0,          0, 32'h0000_501C, 1, 0);
        vecs[33] = mk(0, 1, 26'h10,  0, 16'h0,    0, 32'h0,          0, 32'h0000_4180, 0, 0);

        clearInputs();
        rst = 1'b1;
        #12;
        pushExpect(32'h0000_3000, 1'b0, 1'b0);
        checkOutput("reset");
        rst = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i));
        end

        // Async reset mid-stall must drop the buffered redirect immediately.
        clearInputs();
        stall = 1'b1; jump_en = 1'b1; jump_index = 26'h40;
        pushExpect(32'h0000_4180, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("stall_before_rst");
        #2;
        rst = 1'b1;
        #1;
        pushExpect(32'h0000_3000, 1'b0, 1'b0);
        checkOutput("async_rst");
        clearInputs();
        stall = 1'b1;
        #1;
        rst = 1'b0;
        pushExpect(32'h0000_3000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_release_stalled");
        stall = 1'b0;
        pushExpect(32'h0000_3004, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("stall_release_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC and consumes the jump-target format {PC+4[31:28], index[25:0], 2'b00}.
- Computes the next fetch address from sequential, branch, jump, jump-register and exception requests.
- Holds one pending redirect while the fetch stage is stalled.
- Sits between decode/execute (request side) and instruction memory (PC side).

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_PC, 32'h0000_4180, exception vector; must be word-aligned

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC this cycle
jump_en  in  1  J/JAL request
jump_index  in  26  instr_index field of J/JAL
branch_en  in  1  taken-branch request
branch_offset  in  16  signed word offset of branch
jr_en  in  1  JR/JALR request
jr_target  in  32  register target for JR
exc_en  in  1  exception redirect request
pc  out  32  current fetch address
pc_add4  out  32  pc + 4 (combinational from pc)
redirect_pending  out  1  a redirect is buffered during stall
misalign_exc  out  1  one-cycle pulse: JR target not word-aligned

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, pending register cleared.
  - redirect_pending=0, misalign_exc=0.
  - rst deasserting mid-stall leaves no stale pending redirect.
- Target computation, all modulo 2^32:
  - jump: {pc_add4[31:28], jump_index, 2'b00}, using pc_add4 of the cycle the request is sampled.
  - branch: pc_add4 + (sign_extend(branch_offset) << 2).
  - jr: jr_target.
  - exc: EXC_PC.
- Priority among simultaneous requests: exc > jr > jump > branch > sequential (pc_add4).
- Misaligned JR (jr_en=1 and jr_target[1:0]!=0, with no exc_en): treated as an exception.
  - Target becomes EXC_PC.
  - misalign_exc=1 for exactly the next cycle, registered.
- stall=0, no pending: pc <= selected target at the next edge; latency 1 cycle.
- stall=1: pc holds.
  - Any request is captured into the one-entry pending register as a resolved target, with redirect_pending=1 from the next cycle.
  - A later request during the same stall overwrites the pending entry (latest wins), except that a pending exception is sticky and is not overwritten by non-exception requests.
- Stall release (stall=0, redirect_pending=1):
  - Pending exception beats any new request.
  - Otherwise a new request in the release cycle beats the pending entry.
  - Otherwise pc <= pending target.
  - Pending is cleared at that edge.
- Wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000. Jump region is taken from the wrapped pc_add4.
- misalign_exc under stall: still pulses on the cycle after detection; the redirect itself is deferred as pending.
- Outputs pc and redirect_pending are registered. pc_add4 is combinational.

Decomposition:
- Shared package holds:
  - redirect-kind encoding: NONE, BRANCH, JUMP, JR, EXC (3 bits);
  - constant WORD_BYTES=4;
  - default RESET_PC and EXC_PC values.
- Natural sub-module: pc_target_sel.
  - Combinational; computes the four targets, priority-select and misalign detect.
  - The top level holds the pc register, the pending register with its kind field, and the misalign pulse flop.

Test Plan:
1. Reset then free-run 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C. Assert rst mid-run -> pc=0x3000 immediately (async).
2. pc=0x1000_0040, jump_en=1, jump_index=26'h0000_123 -> next pc = 0x1000_048C. Repeat at pc=0xFFFF_FFFC with index 0 -> next pc 0x0000_0000.
3. pc=0x3010, branch_en=1, branch_offset=16'hFFFE -> next pc 0x300C. Same cycle jump_en=1 -> jump wins.
4. stall=1 for 3 cycles, jump_en pulse in cycle 1 (index 26'h40) -> pc held, redirect_pending=1. Release -> pc=0x0000_0100, pending cleared. Repeat with exc_en in cycle 1 and branch in cycle 2 -> release gives 0x4180.
5. jr_en=1, jr_target=0x0000_3002 -> next pc 0x4180, misalign_exc high exactly one cycle. jr_target=0x0000_3400 -> pc 0x3400, no pulse.
6. All of exc_en, jr_en, jump_en, branch_en high together -> pc 0x4180. Drop exc_en -> jr_target chosen.
